// File: rtl/led_seq_ctrl_pkg.sv
// Shared types and constants for the LED demux sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_UP       = 2'b00,
        MODE_DOWN     = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_HOLD     = 2'b11
    } mode_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam int NUM_POS      = 8;
    localparam int CTRL_W       = 3;
    localparam int LEN_LINEAR   = 8;
    localparam int LEN_PINGPONG = 14;
    localparam int PASS_W       = 4;

    // Pass-count value at which the final dwell of a one-shot ends.
    function automatic logic [PASS_W-1:0] last_pass(input mode_e m);
        return (m == MODE_PINGPONG) ? PASS_W'(LEN_PINGPONG - 1) : PASS_W'(LEN_LINEAR - 1);
    endfunction

    function automatic logic [CTRL_W-1:0] start_pos(input mode_e m);
        return (m == MODE_DOWN) ? CTRL_W'(NUM_POS - 1) : '0;
    endfunction

endpackage

// File: rtl/led_seq_ctrl_if.sv
// Control request inputs and demux drive outputs of the LED sequencer.
interface led_seq_ctrl_if #(parameter int DIV_W = 16);

    logic                          start;
    logic                          stop;
    logic [1:0]                    mode;
    logic                          one_shot;
    logic [DIV_W-1:0]              div;
    logic [led_seq_pkg::CTRL_W-1:0] demux_ctrl;
    logic                          demux_en;
    logic                          demux_in;
    logic                          busy;
    logic                          step;
    logic                          done;

    modport master (
        output start, stop, mode, one_shot, div,
        input  demux_ctrl, demux_en, demux_in, busy, step, done
    );

    modport slave (
        input  start, stop, mode, one_shot, div,
        output demux_ctrl, demux_en, demux_in, busy, step, done
    );

endinterface

// File: rtl/led_seq_ctrl_tick_div.sv
// Step-rate prescaler: tick fires every div+1 enabled cycles.
module tick_div #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;
    logic             term;

    assign term = (count_q == div);
    assign tick = en && term;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = term ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED demux sequencer: walks the active demux output through a pattern.
//   state  | meaning
//   S_IDLE | outputs parked at zero, waiting for start
//   S_RUN  | demux enabled, position advances on each divider tick
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    led_seq_ctrl_if.slave  bus
);

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic                one_shot_q, one_shot_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic                dir_up_q, dir_up_d;
    logic                in_q, in_d;
    logic                busy_q, busy_d;
    logic                step_q, step_d;
    logic                done_q, done_d;
    logic [PASS_W-1:0]   pass_q, pass_d;
    logic                tick;

    localparam logic [CTRL_W-1:0] POS_MAX = CTRL_W'(NUM_POS - 1);

    tick_div #(.DIV_W(DIV_W)) u_tick_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == S_RUN),
        .clr   (state_q == S_IDLE),
        .div   (div_q),
        .tick  (tick)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        one_shot_d = one_shot_q;
        div_d      = div_q;
        ctrl_d     = ctrl_q;
        dir_up_d   = dir_up_q;
        in_d       = in_q;
        busy_d     = busy_q;
        pass_d     = pass_q;
        step_d     = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d    = S_RUN;
                    mode_d     = mode_e'(bus.mode);
                    one_shot_d = bus.one_shot;
                    div_d      = bus.div;
                    ctrl_d     = start_pos(mode_e'(bus.mode));
                    dir_up_d   = 1'b1;
                    in_d       = 1'b1;
                    busy_d     = 1'b1;
                    pass_d     = '0;
                end
            end
            S_RUN: begin
                // stop outranks a coincident tick, including the final one
                if (bus.stop || (tick && one_shot_q && pass_q == last_pass(mode_q))) begin
                    state_d = S_IDLE;
                    ctrl_d  = '0;
                    in_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = !bus.stop;
                end else if (tick) begin
                    step_d = 1'b1;
                    pass_d = pass_q + 1'b1;
                    case (mode_q)
                        MODE_UP:   ctrl_d = ctrl_q + 1'b1;
                        MODE_DOWN: ctrl_d = ctrl_q - 1'b1;
                        MODE_PINGPONG: begin
                            if (dir_up_q) begin
                                ctrl_d   = (ctrl_q == POS_MAX) ? ctrl_q - 1'b1 : ctrl_q + 1'b1;
                                dir_up_d = (ctrl_q != POS_MAX);
                            end else begin
                                ctrl_d   = (ctrl_q == '0) ? ctrl_q + 1'b1 : ctrl_q - 1'b1;
                                dir_up_d = (ctrl_q == '0);
                            end
                        end
                        MODE_HOLD: in_d = !in_q;
                        default:   ctrl_d = ctrl_q;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mode_q     <= MODE_UP;
            one_shot_q <= 1'b0;
            div_q      <= '0;
            ctrl_q     <= '0;
            dir_up_q   <= 1'b1;
            in_q       <= 1'b0;
            busy_q     <= 1'b0;
            step_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            one_shot_q <= one_shot_d;
            div_q      <= div_d;
            ctrl_q     <= ctrl_d;
            dir_up_q   <= dir_up_d;
            in_q       <= in_d;
            busy_q     <= busy_d;
            step_q     <= step_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign bus.demux_ctrl = ctrl_q;
    assign bus.demux_en   = busy_q;
    assign bus.demux_in   = in_q;
    assign bus.busy       = busy_q;
    assign bus.step       = step_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Vector-table bench for led_seq_ctrl plus a hand-written async reset sequence.
module tb_led_seq_ctrl;

    typedef struct {
        logic        start;
        logic        stop;
        logic [1:0]  mode;
        logic        one_shot;
        logic [15:0] div;
        logic [2:0]  ctrl;
        logic        en;
        logic        din;
        logic        busy;
        logic        step;
        logic        done;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    vec_t vq[$];
    int   pp[14] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1};

    led_seq_ctrl_if #(.DIV_W(16)) bus ();

    led_seq_ctrl #(.DIV_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] outs();
        return {bus.demux_ctrl, bus.demux_en, bus.demux_in, bus.busy, bus.step, bus.done};
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got ctrl/en/in/busy/step/done=%b, expected %b", name, got, exp);
        end
    endtask

    task automatic add(input logic s, input logic p, input logic [1:0] m, input logic os,
                       input logic [15:0] d, input int c, input logic din, input logic st,
                       input logic dn, input logic run);
        vq.push_back(vec_t'{s, p, m, os, d, 3'(c), run, din, run, st, dn});
    endtask

    // Idle input, running output.
    task automatic r(input int c, input logic din, input logic st);
        add(0, 0, 2'b00, 0, 16'd0, c, din, st, 0, 1);
    endtask

    // Inputs given, parked output.
    task automatic z(input logic s, input logic p, input logic dn);
        add(s, p, 2'b00, 0, 16'd0, 0, 0, 0, dn, 0);
    endtask

    task automatic run_queue(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            bus.start    = vq[i].start;
            bus.stop     = vq[i].stop;
            bus.mode     = vq[i].mode;
            bus.one_shot = vq[i].one_shot;
            bus.div      = vq[i].div;
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d]", tag, i), outs(),
                {vq[i].ctrl, vq[i].en, vq[i].din, vq[i].busy, vq[i].step, vq[i].done});
        end
        vq.delete();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.start = 0; bus.stop = 0; bus.mode = 0; bus.one_shot = 0; bus.div = 0;
        #1;
        chk("reset", outs(), 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // UP, one-shot, 4-cycle dwell
        add(1, 0, 2'b00, 1, 16'd3, 0, 1, 0, 0, 1);
        for (int k = 1; k < 32; k++) r(k / 4, 1, (k % 4) == 0);
        z(0, 0, 1);
        z(0, 0, 0);
        run_queue("up_oneshot");

        // DOWN, continuous, every cycle; a second start mid-run is ignored
        add(1, 0, 2'b01, 0, 16'd0, 7, 1, 0, 0, 1);
        for (int k = 1; k < 10; k++)
            add(k == 3, 0, 2'b00, 1, 16'd5, (7 - k) & 7, 1, 1, 0, 1);
        z(0, 1, 0);
        z(0, 0, 0);
        run_queue("down_cont");

        // PINGPONG one-shot, then HOLD started in the done cycle
        add(1, 0, 2'b10, 1, 16'd1, 0, 1, 0, 0, 1);
        for (int k = 1; k < 28; k++) r(pp[k / 2], 1, (k % 2) == 0);
        z(0, 0, 1);
        add(1, 0, 2'b11, 1, 16'd2, 0, 1, 0, 0, 1);
        for (int k = 1; k < 24; k++) r(0, ((k / 3) % 2) == 0, (k % 3) == 0);
        z(0, 0, 1);
        z(0, 0, 0);
        run_queue("pp_hold");

        // start with stop, stop while idle, and div/mode changes mid-run
        z(1, 1, 0);
        z(0, 1, 0);
        add(1, 0, 2'b00, 0, 16'd3, 0, 1, 0, 0, 1);
        for (int k = 1; k < 12; k++) add(0, 0, 2'b01, 1, 16'd0, k / 4, 1, (k % 4) == 0, 0, 1);
        z(0, 1, 0);
        z(0, 0, 0);
        run_queue("edges");

        // stop lands on the final one-shot tick
        add(1, 0, 2'b00, 1, 16'd0, 0, 1, 0, 0, 1);
        for (int k = 1; k < 8; k++) r(k, 1, 1);
        z(0, 1, 0);
        z(0, 0, 0);
        z(0, 0, 0);
        run_queue("stop_final");

        // async reset mid-run, asserted between clock edges
        add(1, 0, 2'b00, 0, 16'd3, 0, 1, 0, 0, 1);
        for (int k = 1; k < 6; k++) r(k / 4, 1, (k % 4) == 0);
        run_queue("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_immediate", outs(), 8'h00);
        repeat (2) @(negedge clk);
        chk("async_rst_held", outs(), 8'h00);
        rst_n = 1'b1;

        add(1, 0, 2'b00, 1, 16'd0, 0, 1, 0, 0, 1);
        for (int k = 1; k < 8; k++) r(k, 1, 1);
        z(0, 0, 1);
        z(0, 0, 0);
        run_queue("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
Timed sequencer that drives the 1-to-8 LED demultiplexer's select, enable and data inputs (demux_ctrl[2:0], demux_en, demux_in).
- Walks the active output through a selectable pattern at a programmable rate.
- Runs either continuously or as a one-shot that reports completion.
- Sits between the board-level control inputs and the demux instance.

Parameters:
DIV_W, 16, width of the step-period divider value.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request; begins a sequence when idle
stop  in  1  single-cycle request; aborts the sequence
mode  in  2  pattern select, sampled at start: 00 UP, 01 DOWN, 10 PINGPONG, 11 HOLD
one_shot  in  1  sampled at start; 1 = finish after one pattern pass
div  in  DIV_W  dwell per position minus one, in clk cycles; sampled at start
demux_ctrl  out  3  demux select (active position)
demux_en  out  1  demux enable
demux_in  out  1  demux data bit
busy  out  1  high while sequencing
step  out  1  one-cycle pulse, coincident with each new position/value
done  out  1  one-cycle pulse when a one-shot completes

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n). Reset is asserted on the falling edge of rst_n and released synchronously to clk.
- All outputs are registered.
- Reset values and IDLE values: demux_ctrl=0, demux_en=0, demux_in=0, busy=0, step=0, done=0.
- States: IDLE, RUN.
- IDLE -> RUN when start=1 and stop=0. On the next edge:
  - mode, one_shot and div are latched.
  - busy=1, demux_en=1, demux_in=1, divider=0, pass counter=0.
  - Initial demux_ctrl: UP 0, DOWN 7, PINGPONG 0 (direction up), HOLD 0.
- Divider: counts 0..div_q. A tick fires when count==div_q, and the count returns to 0. Each position therefore dwells div_q+1 cycles; div=0 advances every cycle.
- On a tick in RUN, if the sequence does not finish:
  - UP: ctrl+1, wraps 7->0.
  - DOWN: ctrl-1, wraps 0->7.
  - PINGPONG: 0,1,..,7,6,..,1,0,1,...; direction flips at 7 and at 0; endpoints are not repeated.
  - HOLD: ctrl stays 0; demux_in toggles.
  - step=1 in the cycle the new value appears.
- One-shot length L, in dwells: UP/DOWN/HOLD 8, PINGPONG 14. The pass counter increments per tick.
- On the tick that completes dwell L, in the next cycle:
  - FSM goes to IDLE and all outputs take IDLE values.
  - done=1 for exactly one cycle; step stays 0.
- Continuous mode: no pass limit; done is never asserted.
- stop=1 in RUN -> IDLE next cycle. No done.
- stop has priority over a simultaneous tick or completion: no step, no done.
- stop in IDLE: no effect. start+stop in the same IDLE cycle: remain IDLE.
- start during RUN is ignored. Changes to mode/div/one_shot during RUN are ignored.
- Asynchronous reset mid-run: outputs return to reset values immediately, without waiting for clk. The first start after release behaves as from reset.
- Throughput: a new start is accepted in the cycle done is high, since the FSM is already IDLE.

Decomposition:
- Package led_seq_pkg:
  - mode_e (MODE_UP, MODE_DOWN, MODE_PINGPONG, MODE_HOLD)
  - state_e (S_IDLE, S_RUN)
  - NUM_POS=8, CTRL_W=3, LEN_LINEAR=8, LEN_PINGPONG=14
- One sub-module, tick_div: prescaler with clk, rst_n, en, clr, div[DIV_W] inputs and tick output. Parent holds the FSM, position/direction and pass counter.

Test Plan:
1. Reset, start UP one_shot=1 div=3 -> ctrl 0,1,..,7 each held 4 cycles, en=1, in=1; step 7 times; 32 busy cycles, then done high 1 cycle with outputs 0.
2. DOWN one_shot=0 div=0 -> ctrl 7,6,..,0,7,6 changing every cycle, step every cycle; stop pulse -> next cycle en=0, ctrl=0, busy=0, done stays 0.
3. PINGPONG one_shot=1 div=1 -> ctrl 0,1,2,3,4,5,6,7,6,5,4,3,2,1 each 2 cycles; done pulses after 28 busy cycles.
4. HOLD one_shot=1 div=2 -> ctrl fixed 0; in 1,0,1,0,1,0,1,0 each 3 cycles; done after 24 busy cycles.
5. Edge cases:
   - start+stop in the same cycle -> stays IDLE.
   - Second start mid-run -> sequence continues unchanged.
   - div changed 3->0 mid-run -> dwell stays 4.
   - stop coincident with the final tick -> no done.
6. rst_n low mid-run, asserted between clk edges -> outputs 0 immediately; after release, start UP div=0 one_shot=1 -> clean 0..7 run and done.
